quad_dec_mod: RTL and testbench



---
 rtl/quad_dec_mod.sv | 149 ++++++++++++++
 tb/tb_quad_dec_mod.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/quad_dec_mod.sv
// Quadrature A/B decoder driving a modulo-MOD position counter with step/wrap strobes.
// Optional per-channel glitch filter enabled by defining GLITCH_FILTER_EN.
module quad_dec_mod #(
    parameter int unsigned MOD         = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a,
    input  logic                   b,
    input  logic                   en,
    output logic [$clog2(MOD)-1:0] pos,
    output logic                   dir,
    output logic                   step,
    output logic                   wrap,
    output logic                   err
);
    localparam int unsigned W = $clog2(MOD);

    typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DOWN, MV_ILL} move_t;

    logic [SYNC_STAGES-1:0] a_sr, b_sr;
    logic                   a_sync, b_sync;
    logic [1:0]             s, prev;
    logic                   primed;
    move_t                  move;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr <= '0;
            b_sr <= '0;
        end else begin
            a_sr <= {a_sr[SYNC_STAGES-2:0], a};
            b_sr <= {b_sr[SYNC_STAGES-2:0], b};
        end
    end

    assign a_sync = a_sr[SYNC_STAGES-1];
    assign b_sync = b_sr[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FW       = $clog2(FILT_CYC + 1);
    localparam int unsigned FILT_LAT = FILT_CYC;

    logic          a_f, b_f;
    logic [FW-1:0] a_fc, b_fc;

    // Output follows the synchronised input only after FILT_CYC consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_f  <= 1'b0;
            b_f  <= 1'b0;
            a_fc <= '0;
            b_fc <= '0;
        end else begin
            if (a_sync == a_f) begin
                a_fc <= '0;
            end else if (a_fc == FW'(FILT_CYC - 1)) begin
                a_f  <= a_sync;
                a_fc <= '0;
            end else begin
                a_fc <= a_fc + 1'b1;
            end
            if (b_sync == b_f) begin
                b_fc <= '0;
            end else if (b_fc == FW'(FILT_CYC - 1)) begin
                b_f  <= b_sync;
                b_fc <= '0;
            end else begin
                b_fc <= b_fc + 1'b1;
            end
        end
    end

    assign s = {a_f, b_f};
`else
    localparam int unsigned FILT_LAT = FILT_CYC * 0;

    assign s = {a_sync, b_sync};
`endif

    localparam int unsigned PRIME_CYC = SYNC_STAGES + FILT_LAT;
    localparam int unsigned PCW       = $clog2(PRIME_CYC + 1);

    logic [PCW-1:0] pcnt;

    always_comb begin
        move = MV_NONE;
        if (s != prev) begin
            case ({prev, s})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MV_UP;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MV_DOWN;
                default:                                move = MV_ILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev   <= '0;
            primed <= 1'b0;
            pcnt   <= '0;
            pos    <= '0;
            dir    <= 1'b0;
            step   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (!primed) begin
                // Hold off until the pipeline has flushed its reset zeros.
                if (pcnt == PCW'(PRIME_CYC)) begin
                    prev   <= s;
                    primed <= 1'b1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end else begin
                prev <= s;
                case (move)
                    MV_ILL: err <= 1'b1;
                    MV_UP: if (en) begin
                        step <= 1'b1;
                        dir  <= 1'b1;
                        if (pos == W'(MOD - 1)) begin
                            pos  <= '0;
                            wrap <= 1'b1;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                    MV_DOWN: if (en) begin
                        step <= 1'b1;
                        dir  <= 1'b0;
                        if (pos == '0) begin
                            pos  <= W'(MOD - 1);
                            wrap <= 1'b1;
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_quad_dec_mod.sv
// Bench for quad_dec_mod: directed scenarios plus random walk, checked against a phase-index model.
module tb_quad_dec_mod;
    localparam int MOD = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       en = 1'b1;
    logic [3:0] pos;
    logic       dir, step, wrap, err;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Model: encoder phase index 0..3 along the up sequence 00,10,11,01.
    int m_ph, m_pos, m_dir, m_err;
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_dec_mod #(.MOD(12), .SYNC_STAGES(2), .FILT_CYC(4)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .en(en),
        .pos(pos), .dir(dir), .step(step), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int phase_of(input logic [1:0] c);
        for (int i = 0; i < 4; i++) if (seq[i] == c) return i;
        return 0;
    endfunction

    task automatic check_state(input string tag, input int sc, input int wc, input int esc, input int ewc);
        chk({tag, ".pos"},   int'(pos), m_pos);
        chk({tag, ".dir"},   int'(dir), m_dir);
        chk({tag, ".err"},   int'(err), m_err);
        chk({tag, ".steps"}, sc, esc);
        chk({tag, ".wraps"}, wc, ewc);
        chk({tag, ".idle"},  int'(step) + int'(wrap), 0);
    endtask

    task automatic do_reset(input logic [1:0] c);
        reset = 1'b1;
        a = c[1];
        b = c[0];
        @(posedge clk); #1;
        chk("reset.pos",  int'(pos),  0);
        chk("reset.dir",  int'(dir),  0);
        chk("reset.step", int'(step), 0);
        chk("reset.wrap", int'(wrap), 0);
        chk("reset.err",  int'(err),  0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        m_pos = 0; m_dir = 0; m_err = 0; m_ph = phase_of(c);
        chk("prime.steps", int'(step), 0);
    endtask

    task automatic apply(input logic [1:0] c, input logic e, input string tag);
        int sc, wc, d, esc, ewc;
        a = c[1];
        b = c[0];
        en = e;
        sc = 0;
        wc = 0;
        repeat (8) begin
            @(posedge clk); #1;
            sc += int'(step);
            wc += int'(wrap);
        end
        d = (phase_of(c) - m_ph + 4) % 4;
        esc = 0;
        ewc = 0;
        if (d == 2) begin
            m_err = 1;
        end else if (d != 0 && e) begin
            esc = 1;
            if (d == 1) begin
                m_dir = 1;
                m_pos = m_pos + 1;
                if (m_pos == MOD) begin m_pos = 0; ewc = 1; end
            end else begin
                m_dir = 0;
                m_pos = m_pos - 1;
                if (m_pos < 0) begin m_pos = MOD - 1; ewc = 1; end
            end
        end
        m_ph = phase_of(c);
        check_state(tag, sc, wc, esc, ewc);
    endtask

    function automatic logic [1:0] rel(input int delta);
        return seq[(m_ph + delta + 4) % 4];
    endfunction

    initial begin
        int wtot, r;
        logic e;

        // Full up cycle 0 -> 4
        do_reset(2'b00);
        apply(2'b10, 1'b1, "t1.e1");
        apply(2'b11, 1'b1, "t1.e2");
        apply(2'b01, 1'b1, "t1.e3");
        apply(2'b00, 1'b1, "t1.e4");
        chk("t1.pos4", int'(pos), 4);

        // Down from 0 wraps to MOD-1
        do_reset(2'b00);
        apply(2'b01, 1'b1, "t2.down");
        chk("t2.pos11", int'(pos), 11);
        apply(2'b00, 1'b1, "t2.back");

        // Twelve up edges: one wrap total
        wtot = 0;
        for (int i = 0; i < 12; i++) begin
            apply(rel(1), 1'b1, "t3.up");
            wtot += (m_pos == 0) ? 1 : 0;
        end
        chk("t3.pos0", int'(pos), 0);
        chk("t3.wraps", wtot, 1);

        // Disabled edges are tracked but not counted
        for (int i = 0; i < 3; i++) apply(rel(1), 1'b0, "t4.dis");
        apply(rel(1), 1'b1, "t4.en");
        chk("t4.pos1", int'(pos), 1);

        // Random walk, legal edges only
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 2));
            e = ($urandom_range(0, 3) != 0);
            apply(rel(r == 2 ? -1 : r), e, "rnd");
        end

`ifdef GLITCH_FILTER_EN
        do_reset(2'b00);
        a = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        a = 1'b0;
        begin
            int sc = 0;
            repeat (10) begin @(posedge clk); #1; sc += int'(step); end
            chk("t6.glitch.steps", sc, 0);
            chk("t6.glitch.pos", int'(pos), 0);
        end
        apply(2'b10, 1'b1, "t6.hold");
        chk("t6.pos1", int'(pos), 1);
`endif

        // Illegal jump sets sticky err; reset clears it
        do_reset(2'b00);
        apply(2'b10, 1'b1, "t5.pre");
        apply(2'b01, 1'b1, "t5.ill");
        chk("t5.err", int'(err), 1);
        apply(2'b00, 1'b1, "t5.after");
        chk("t5.sticky", int'(err), 1);
        do_reset(2'b00);
        chk("t5.clr.err", int'(err), 0);
        chk("t5.clr.pos", int'(pos), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
